rp_axi_rd_sm: RTL and testbench
===============================

// Module: rp_axi_rd_sm
// PURPOSE
//  AXI playback engine: reads 64-bit words from a DDR ring buffer [start,stop) via a burst read master.
//  Unpacks each word into 4 x 16-bit samples for the DAC/generator path.
//  Counterpart of the acquisition write engine; same buffer layout, sample 0 in bits [15:0].
// PARAMETERS
//  DW  14  output sample width; low DW bits of each 16-bit lane
//  FW  5   log2 of word FIFO depth (default 32 words); must be >= 5
// PORTS
//  axi_clk_i        in   1   clock
//  axi_rstn_i       in   1   asynchronous reset, active low
//  axi_raddr_o      out  32  burst read address, 8-byte aligned
//  axi_rlen_o       out  4   burst length-1, constant 4'hF (16 beats)
//  axi_rvalid_o     out  1   read request valid
//  axi_rrdy_i       in   1   request accepted when high together with axi_rvalid_o
//  axi_rdata_i      in   64  read data beat
//  axi_rdv_i        in   1   read data beat valid
//  axi_rlast_i      in   1   last beat of burst
//  axi_rerr_i       in   1   read error, sampled with axi_rdv_i
//  set_axi_en_i     in   1   playback enable (level)
//  set_axi_start_i  in   32  buffer start address; 128-byte aligned
//  set_axi_stop_i   in   32  buffer stop address, exclusive; (stop-start) is a multiple of 128
//  dac_start_i      in   1   start pulse: clear and begin fetching from start
//  dac_rst_i        in   1   stop pulse: clear and return to idle
//  dac_rd_i         in   1   sample request strobe from DAC path
//  dac_dat_o        out  DW  output sample
//  dac_dv_o         out  1   dac_dat_o valid (registered response to dac_rd_i)
//  axi_rp_cur_o     out  32  address of last accepted burst request
//  axi_uf_cnt_o     out  32  underflow counter (see CONFIGURATION)
//  axi_state_o      out  8   {4'h0, uf_sticky, err_sticky, state[1:0]}
// BEHAVIOUR
//  Reset: all outputs 0; axi_rlen_o = 4'hF always; FIFO empty, state IDLE, next address = 0.
//  clr = dac_start_i | dac_rst_i: flush FIFO, sample select = 0, next addr <= set_axi_start_i,
//   axi_rp_cur_o <= set_axi_start_i, sticky flags cleared; dac_start_i also sets run, dac_rst_i clears run.
//  States (2-bit): IDLE=0, REQ=1, DATA=2, DRAIN=3.
//   IDLE->REQ: run & set_axi_en_i & free >= 16 (free = 2^FW - level; one burst outstanding max).
//   REQ: axi_rvalid_o=1, axi_raddr_o=next addr; on axi_rrdy_i -> DATA, axi_rp_cur_o <= addr,
//    next = addr+128, wraps to start when addr+128 >= stop.
//   DATA: each axi_rdv_i pushes one word; on axi_rdv_i & axi_rlast_i -> IDLE.
//   clr while in DATA -> DRAIN: remaining beats discarded; on rlast -> IDLE. clr in REQ -> IDLE (request dropped).
//   set_axi_en_i low: no new request; outstanding burst completes normally.
//  Output: dac_rd_i in cycle n -> dac_dv_o=1 and dac_dat_o=lane[sel][DW-1:0] in cycle n+1; sel++;
//   word popped when sel wraps 3->0. Simultaneous push and pop: level unchanged.
//  Underflow: dac_rd_i with FIFO empty -> dac_dv_o=1, dac_dat_o holds previous value, uf_sticky=1, sel unchanged.
//  axi_rerr_i & axi_rdv_i -> err_sticky=1; word still pushed. Sticky bits cleared only by clr/reset.
//  Async reset mid-burst: engine returns to IDLE; interconnect reset is handled by the system.
// CONFIGURATION
//  RP_AXI_RD_UF_CNT_EN defined: axi_uf_cnt_o counts underflow reads, saturating at 32'hFFFFFFFF,
//   cleared by clr. Undefined: axi_uf_cnt_o tied to 32'h0, no counter logic.
// TESTING
//  start=0x1000, stop=0x1100, en=1, dac_start_i pulse -> requests at 0x1000, 0x1080, then 0x1000 (wrap).
//  Burst word k = {4{16'(k)}}, dac_rd_i every cycle -> dac_dat_o 0,0,0,0,1,1,1,1... one cycle after each strobe.
//  dac_rd_i continuous, no reads returned -> dac_dat_o held, uf bit set, with macro axi_uf_cnt_o increments per read.
//  FIFO at 2^FW-8 words -> no axi_rvalid_o until level <= 2^FW-16.
//  dac_rst_i after 5 beats of a burst -> state DRAIN, remaining 11 beats discarded, FIFO empty, then IDLE.
//  axi_rerr_i on beat 3 -> axi_state_o[2]=1, data of beat 3 still output.

Source files
------------

// File: rtl/rp_axi_rd_sm.sv
// rp_axi_rd_sm: burst-read playback engine, DDR ring [start,stop) -> word FIFO -> 4 x 16-bit samples.
// Build option RP_AXI_RD_UF_CNT_EN adds a saturating underflow-read counter on axi_uf_cnt_o.
module rp_axi_rd_sm #(
  parameter int DW = 14,
  parameter int FW = 5   // FIFO must hold at least two bursts (FW >= 5)
) (
  input  logic          axi_clk_i,
  input  logic          axi_rstn_i,
  output logic [31:0]   axi_raddr_o,
  output logic [3:0]    axi_rlen_o,
  output logic          axi_rvalid_o,
  input  logic          axi_rrdy_i,
  input  logic [63:0]   axi_rdata_i,
  input  logic          axi_rdv_i,
  input  logic          axi_rlast_i,
  input  logic          axi_rerr_i,
  input  logic          set_axi_en_i,
  input  logic [31:0]   set_axi_start_i,
  input  logic [31:0]   set_axi_stop_i,
  input  logic          dac_start_i,
  input  logic          dac_rst_i,
  input  logic          dac_rd_i,
  output logic [DW-1:0] dac_dat_o,
  output logic          dac_dv_o,
  output logic [31:0]   axi_rp_cur_o,
  output logic [31:0]   axi_uf_cnt_o,
  output logic [7:0]    axi_state_o
);
  localparam int          DEPTH   = 1 << FW;
  localparam logic [FW:0] LVL_MAX = (FW+1)'(DEPTH - 16);
  localparam logic [31:0] BURST_B = 32'd128;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic [31:0]   addr_q, addr_d, cur_q, cur_d, addr_inc;
  logic          clr, last_beat, push, pop, rd_hit, uf_rd;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic [FW-1:0] wptr_q, rptr_q;
  logic [FW:0]   lvl_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] dat_q;
  logic          dv_q, uf_q, err_q;

  assign clr       = dac_start_i | dac_rst_i;
  assign last_beat = axi_rdv_i & axi_rlast_i;
  assign addr_inc  = addr_q + BURST_B;
  assign push      = (state_q == DATA) & axi_rdv_i & ~clr;
  // a read strobe coincident with a clear is dropped
  assign rd_hit    = dac_rd_i & ~clr & (lvl_q != '0);
  assign uf_rd     = dac_rd_i & ~clr & (lvl_q == '0);
  assign pop       = rd_hit & (sel_q == 2'd3);
  assign head      = mem_q[rptr_q];

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      addr_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    addr_d       = addr_q;
    cur_d        = cur_q;
    axi_rvalid_o = 1'b0;
    case (state_q)
      // one burst outstanding at most, so 16 free words at issue guarantees room
      IDLE: if (run_q && set_axi_en_i && lvl_q <= LVL_MAX) state_d = REQ;
      REQ: begin
        axi_rvalid_o = ~clr;
        if (axi_rrdy_i) begin
          state_d = DATA;
          cur_d   = addr_q;
          addr_d  = (addr_inc >= set_axi_stop_i) ? set_axi_start_i : addr_inc;
        end
      end
      DATA, DRAIN: if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      addr_d = set_axi_start_i;
      cur_d  = set_axi_start_i;
      run_d  = dac_start_i & ~dac_rst_i;
      if (state_q == IDLE || state_q == REQ) state_d = IDLE;
      else if (!last_beat)                   state_d = DRAIN;
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (push) mem_q[wptr_q] <= axi_rdata_i;
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      dv_q   <= 1'b0;
      uf_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dv_q <= dac_rd_i & ~clr;
      if (rd_hit) dat_q <= head[{sel_q, 4'b0000} +: DW];
      if (clr) begin
        wptr_q <= '0;
        rptr_q <= '0;
        lvl_q  <= '0;
        sel_q  <= '0;
        uf_q   <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (push)   wptr_q <= wptr_q + 1'b1;
        if (pop)    rptr_q <= rptr_q + 1'b1;
        if (rd_hit) sel_q  <= sel_q + 2'd1;
        if (push && !pop)      lvl_q <= lvl_q + 1'b1;
        else if (pop && !push) lvl_q <= lvl_q - 1'b1;
        if (uf_rd)               uf_q  <= 1'b1;
        if (push && axi_rerr_i)  err_q <= 1'b1;
      end
    end
  end

`ifdef RP_AXI_RD_UF_CNT_EN
  logic [31:0] ufc_q;
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i)                          ufc_q <= '0;
    else if (clr)                             ufc_q <= '0;
    else if (uf_rd && ufc_q != 32'hFFFF_FFFF) ufc_q <= ufc_q + 32'd1;
  end
  assign axi_uf_cnt_o = ufc_q;
`else
  assign axi_uf_cnt_o = 32'h0;
`endif

  assign axi_raddr_o  = addr_q;
  assign axi_rlen_o   = 4'hF;
  assign axi_rp_cur_o = cur_q;
  assign dac_dat_o    = dat_q;
  assign dac_dv_o     = dv_q;
  assign axi_state_o  = {4'h0, uf_q, err_q, state_q};

endmodule

// File: tb/tb_rp_axi_rd_sm.sv
// Bench for rp_axi_rd_sm: address table, corner sequences, then random traffic vs a sample-queue model.
module tb_rp_axi_rd_sm;
  localparam int DW = 14;
  localparam int FW = 5;
  localparam int DEPTH = 1 << FW;

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic [31:0]   axi_raddr_o;
  logic [3:0]    axi_rlen_o;
  logic          axi_rvalid_o;
  logic          axi_rrdy_i = 1'b0;
  logic [63:0]   axi_rdata_i = '0;
  logic          axi_rdv_i = 1'b0, axi_rlast_i = 1'b0, axi_rerr_i = 1'b0;
  logic          set_axi_en_i = 1'b0;
  logic [31:0]   set_axi_start_i = '0, set_axi_stop_i = '0;
  logic          dac_start_i = 1'b0, dac_rst_i = 1'b0, dac_rd_i = 1'b0;
  logic [DW-1:0] dac_dat_o;
  logic          dac_dv_o;
  logic [31:0]   axi_rp_cur_o, axi_uf_cnt_o;
  logic [7:0]    axi_state_o;

  always #5 gclk = ~gclk;

  rp_axi_rd_sm #(.DW(DW), .FW(FW)) dut (
    .axi_clk_i(gclk), .axi_rstn_i(grst_n),
    .axi_raddr_o(axi_raddr_o), .axi_rlen_o(axi_rlen_o), .axi_rvalid_o(axi_rvalid_o),
    .axi_rrdy_i(axi_rrdy_i), .axi_rdata_i(axi_rdata_i), .axi_rdv_i(axi_rdv_i),
    .axi_rlast_i(axi_rlast_i), .axi_rerr_i(axi_rerr_i), .set_axi_en_i(set_axi_en_i),
    .set_axi_start_i(set_axi_start_i), .set_axi_stop_i(set_axi_stop_i),
    .dac_start_i(dac_start_i), .dac_rst_i(dac_rst_i), .dac_rd_i(dac_rd_i),
    .dac_dat_o(dac_dat_o), .dac_dv_o(dac_dv_o), .axi_rp_cur_o(axi_rp_cur_o),
    .axi_uf_cnt_o(axi_uf_cnt_o), .axi_state_o(axi_state_o)
  );

  int n_cmp = 0, n_bad = 0;

  // model: FIFO seen as a flat queue of 16-bit samples
  logic [15:0]   sq[$];
  logic [DW-1:0] dat_log[$];
  logic [31:0]   acc_log[$];
  logic [DW-1:0] m_dat;
  bit            m_dv, m_uf, m_err, drain, det_data;
  logic [31:0]   m_cnt, m_addr, m_cur;
  int            beats_left, err_beat;
  int unsigned   rd_pct, rdy_pct, dv_pct, err_pct;

  typedef struct {
    logic [31:0] start, stop, a0, a1, a2;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef RP_AXI_RD_UF_CNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  function automatic int m_lvl();
    return (sq.size() + 3) / 4;
  endfunction

  task automatic do_reset();
    #2;
    grst_n = 1'b0;
    dac_start_i = 0; dac_rst_i = 0; dac_rd_i = 0;
    axi_rrdy_i = 0; axi_rdv_i = 0; axi_rlast_i = 0; axi_rerr_i = 0;
    beats_left = 0; drain = 0; sq.delete();
    m_dat = '0; m_dv = 0; m_uf = 0; m_err = 0; m_cnt = '0; m_addr = '0; m_cur = '0;
    #1;
    chk("rst_dv", dac_dv_o, 0);
    chk("rst_dat", dac_dat_o, 0);
    chk("rst_rvalid", axi_rvalid_o, 0);
    chk("rst_raddr", axi_raddr_o, 0);
    chk("rst_cur", axi_rp_cur_o, 0);
    chk("rst_ufcnt", axi_uf_cnt_o, 0);
    chk("rst_state", axi_state_o, 0);
    chk("rst_rlen", axi_rlen_o, 4'hF);
    @(posedge gclk); #1;
    grst_n = 1'b1;
  endtask

  // one clock: drive inputs, step, advance model, compare
  task automatic cyc(input bit sp, input bit rp);
    bit clr, rd, acc, beat, perr;
    logic [31:0] a;
    logic [63:0] w;
    logic [15:0] s;
    clr = sp | rp;
    dac_start_i = sp;
    dac_rst_i   = rp;
    rd = !clr && ($urandom_range(99) < rd_pct);
    dac_rd_i = rd;
    axi_rrdy_i = !clr && ($urandom_range(99) < rdy_pct);
    beat = (beats_left > 0) && ($urandom_range(99) < dv_pct);
    w = det_data ? {4{16'(16 - beats_left)}} : {$urandom, $urandom};
    perr = beat && ((err_beat == 16 - beats_left) || ($urandom_range(99) < err_pct));
    axi_rdv_i   = beat;
    axi_rlast_i = beat && (beats_left == 1);
    axi_rerr_i  = perr;
    axi_rdata_i = beat ? w : 64'h0;
    #1;
    acc = axi_rvalid_o && axi_rrdy_i;
    a   = axi_raddr_o;
    @(posedge gclk); #1;
    m_dv = rd;
    if (rd) begin
      if (sq.size() == 0) begin
        m_uf = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else begin
        s = sq.pop_front();
        m_dat = s[DW-1:0];
      end
    end
    if (beat) begin
      if (!drain && !clr) begin
        for (int i = 0; i < 4; i++) sq.push_back(w[16*i +: 16]);
        if (perr) m_err = 1;
      end
      beats_left--;
      if (beats_left == 0) drain = 0;
    end
    if (acc) begin
      chk("raddr", a, m_addr);
      acc_log.push_back(a);
      m_cur  = a;
      m_addr = (a + 32'd128 >= set_axi_stop_i) ? set_axi_start_i : a + 32'd128;
      beats_left = 16;
    end
    if (clr) begin
      sq.delete();
      m_uf = 0; m_err = 0; m_cnt = '0;
      m_addr = set_axi_start_i; m_cur = set_axi_start_i;
      if (beats_left > 0) drain = 1;
    end
    chk("dv", dac_dv_o, m_dv);
    if (m_dv) begin
      chk("dat", dac_dat_o, m_dat);
      dat_log.push_back(dac_dat_o);
    end
    chk("uf_bit", axi_state_o[3], m_uf);
    chk("err_bit", axi_state_o[2], m_err);
    chk("cur", axi_rp_cur_o, m_cur);
    chk("ufcnt", axi_uf_cnt_o, exp_cnt());
    if (axi_rvalid_o) chk("lvl_at_req", m_lvl() <= DEPTH - 16, 1);
  endtask

  task automatic quiesce();
    rd_pct = 0; rdy_pct = 0; dv_pct = 100;
    cyc(0, 1);
    repeat (20) cyc(0, 0);
  endtask

  initial begin
    int n;
    vt[0] = '{32'h0000_1000, 32'h0000_1100, 32'h0000_1000, 32'h0000_1080, 32'h0000_1000};
    vt[1] = '{32'h0000_2000, 32'h0000_2080, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
    vt[2] = '{32'h0000_0000, 32'h0000_0180, 32'h0000_0000, 32'h0000_0080, 32'h0000_0100};
    vt[3] = '{32'h7FFF_FF00, 32'h8000_0000, 32'h7FFF_FF00, 32'h7FFF_FF80, 32'h7FFF_FF00};
    err_beat = -1; err_pct = 0; det_data = 1;
    rd_pct = 0; rdy_pct = 0; dv_pct = 100;
    do_reset();
    cyc(0, 0);

    // address sequence and data ordering per table entry
    for (int v = 0; v < 4; v++) begin
      set_axi_start_i = vt[v].start;
      set_axi_stop_i  = vt[v].stop;
      set_axi_en_i    = 1;
      det_data = 1;
      quiesce();
      acc_log.delete(); dat_log.delete();
      rdy_pct = 100;
      cyc(1, 0);
      n = 0;
      while (acc_log.size() < 1 && n < 50) begin cyc(0, 0); n++; end
      cyc(0, 0); cyc(0, 0);
      rd_pct = 100;
      n = 0;
      while (acc_log.size() < 3 && n < 500) begin cyc(0, 0); n++; end
      chk("v_nacc", acc_log.size() >= 3, 1);
      chk("v_a0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, vt[v].a0);
      chk("v_a1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, vt[v].a1);
      chk("v_a2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, vt[v].a2);
      for (int i = 0; i < 8; i++)
        chk("v_dat", dat_log.size() > i ? dat_log[i] : {DW{1'b1}}, i / 4);
    end

    // underflow: run cleared, FIFO empty, continuous reads
    quiesce();
    rd_pct = 100;
    repeat (10) cyc(0, 0);
    chk("uf_held_bit", axi_state_o[3], 1);
`ifdef RP_AXI_RD_UF_CNT_EN
    chk("uf_cnt10", axi_uf_cnt_o, 10);
`else
    chk("uf_cnt10", axi_uf_cnt_o, 0);
`endif

    // full FIFO: no request until level falls to 16 words
    set_axi_start_i = 32'h0001_0000; set_axi_stop_i = 32'h0001_0800;
    quiesce();
    det_data = 0; acc_log.delete();
    rdy_pct = 100;
    cyc(1, 0);
    n = 0;
    while (!(acc_log.size() == 2 && beats_left == 0) && n < 100) begin cyc(0, 0); n++; end
    chk("full_lvl", m_lvl(), DEPTH);
    rdy_pct = 0; rd_pct = 100;
    repeat (32) cyc(0, 0);
    chk("lvl24_no_req", axi_rvalid_o, 0);
    chk("lvl24", m_lvl(), DEPTH - 8);
    n = 0;
    while (!axi_rvalid_o && n < 80) begin cyc(0, 0); n++; end
    chk("req_seen", axi_rvalid_o, 1);
    chk("lvl_when_req", m_lvl(), DEPTH - 16);

    // clear mid-burst: drain remaining beats, FIFO empty, back to IDLE
    quiesce();
    det_data = 1; acc_log.delete();
    rdy_pct = 100;
    cyc(1, 0);
    n = 0;
    while (beats_left != 11 && n < 60) begin cyc(0, 0); n++; end
    chk("drain_5beats", beats_left, 11);
    rdy_pct = 0;
    cyc(0, 1);
    chk("drain_state", axi_state_o[1:0], 2'd3);
    n = 0;
    while (beats_left != 0 && n < 40) begin cyc(0, 0); n++; end
    chk("drain_idle", axi_state_o[1:0], 2'd0);
    rd_pct = 100;
    cyc(0, 0);
    chk("drain_empty_uf", axi_state_o[3], 1);

    // read error on beat 3: sticky flag, data still delivered
    quiesce();
    err_beat = 3; acc_log.delete();
    rdy_pct = 100;
    cyc(1, 0);
    n = 0;
    while (acc_log.size() < 1 && n < 50) begin cyc(0, 0); n++; end
    rdy_pct = 0;
    n = 0;
    while (beats_left != 0 && n < 50) begin cyc(0, 0); n++; end
    chk("err_sticky", axi_state_o[2], 1);
    dat_log.delete();
    rd_pct = 100;
    repeat (20) cyc(0, 0);
    chk("err_beat3_dat", dat_log.size() > 12 ? dat_log[12] : {DW{1'b1}}, 3);
    chk("err_still", axi_state_o[2], 1);
    err_beat = -1;

    // random traffic with occasional clears and one async reset
    det_data = 0; err_pct = 2;
    for (int seg = 0; seg < 6; seg++) begin
      if (seg == 3) begin
        do_reset();
        cyc(0, 0);
      end
      set_axi_start_i = {18'h0, 7'($urandom_range(0, 127)), 7'h0};
      set_axi_stop_i  = set_axi_start_i + 32'd128 * 32'($urandom_range(1, 4));
      rd_pct  = $urandom_range(10, 100);
      rdy_pct = $urandom_range(20, 100);
      dv_pct  = $urandom_range(20, 100);
      cyc(1, 0);
      for (int i = 0; i < 600; i++) begin
        int unsigned r;
        set_axi_en_i = ($urandom_range(99) < 90);
        r = $urandom_range(199);
        if (r == 0)      cyc(0, 1);
        else if (r == 1) cyc(1, 0);
        else             cyc(0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
